// File: rtl/eight_bit_divider.sv
// eight_bit_divider
// Sequential 8-bit unsigned restoring divider. One shift-and-trial-subtract
// step is performed per clock for 8 clocks. The final step raises a
// one-cycle done pulse together with the quotient and remainder.
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset (highest priority)
//   start        request strobe, accepted only while idle
//   dividend     8-bit unsigned dividend, sampled on the accepting edge
//   divisor      8-bit unsigned divisor, sampled on the accepting edge
//   busy         high while a division is iterating
//   done         one-cycle completion pulse
//   quotient     result quotient, held until the next completion
//   remainder    result remainder, held until the next completion
//   div_by_zero  set with done when the divisor was zero, held likewise
module eight_bit_divider (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [7:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [7:0] quotient,
    output logic [7:0] remainder,
    output logic       div_by_zero
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [8:0] r_q, r_d;          // partial remainder
    logic [7:0] q_q, q_d;          // dividend/quotient shift register
    logic [7:0] d_q, d_d;          // latched divisor
    logic [7:0] quotient_q, quotient_d;
    logic [7:0] remainder_q, remainder_d;
    logic       dbz_q, dbz_d;
    logic       done_q, done_d;

    // Single iteration datapath
    logic [8:0] trial;
    logic [8:0] trial_diff;
    logic       trial_ok;
    logic [8:0] r_step;
    logic [7:0] q_step;

    always_comb begin
        trial      = {r_q[7:0], q_q[7]};
        trial_diff = trial - {1'b0, d_q};
        trial_ok   = (trial >= {1'b0, d_q});
        r_step     = trial_ok ? trial_diff : trial;
        q_step     = {q_q[6:0], trial_ok};
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        r_d         = r_q;
        q_d         = q_q;
        d_d         = d_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor == 8'd0) begin
                        // Divide by zero completes on the accepting edge
                        // without entering RUN.
                        quotient_d  = 8'hFF;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        done_d      = 1'b1;
                    end else begin
                        d_d     = divisor;
                        q_d     = dividend;
                        r_d     = 9'd0;
                        cnt_d   = 3'd7;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                r_d   = r_step;
                q_d   = q_step;
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd0) begin
                    quotient_d  = q_step;
                    remainder_d = r_step[7:0];
                    dbz_d       = 1'b0;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            r_q         <= 9'd0;
            q_q         <= 8'd0;
            d_q         <= 8'd0;
            quotient_q  <= 8'd0;
            remainder_q <= 8'd0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            r_q         <= r_d;
            q_q         <= q_d;
            d_q         <= d_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            done_q      <= done_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_eight_bit_divider.sv
// tb_eight_bit_divider
// Directed-vector bench for eight_bit_divider. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_eight_bit_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int checks;
    int errors;

    eight_bit_divider dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one single-cycle start and check the completion.
    task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] eq, input logic [7:0] er,
                           input logic edbz);
        int lat;
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start = 1'b0;
        if (b == 8'd0) begin
            check("dbz_done_now", done, 1);
            check("dbz_busy_low", busy, 0);
        end else begin
            check("busy_after_start", busy, 1);
            check("done_low_start", done, 0);
            lat = 0;
            while (!done && lat < 20) begin
                @(negedge clk);
                lat++;
                if (busy && done) check("busy_done_overlap", 1, 0);
            end
            check("latency", lat, 8);
            check("busy_at_done", busy, 0);
        end
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("div_by_zero", div_by_zero, edbz);
        $display("div %0d/%0d -> q=%0d r=%0d dbz=%0d", a, b, quotient, remainder, div_by_zero);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
    endtask

    initial begin
        int lat;
        int pulses;
        int last;
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", div_by_zero, 0);

        run_div(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
        run_div(8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
        run_div(8'd5, 8'd9, 8'd0, 8'd5, 1'b0);
        run_div(8'd255, 8'd255, 8'd1, 8'd0, 1'b0);
        run_div(8'd0, 8'd3, 8'd0, 8'd0, 1'b0);
        run_div(8'd77, 8'd0, 8'hFF, 8'd77, 1'b1);
        run_div(8'd77, 8'd5, 8'd15, 8'd2, 1'b0);

        // Start while busy is ignored; operand changes have no effect.
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd3;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        @(negedge clk);
        lat++;
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 8'd2;
        @(negedge clk);
        lat++;
        start    = 1'b0;
        dividend = 8'd55;
        divisor  = 8'd4;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("ignore_latency", lat, 8);
        check("ignore_quotient", quotient, 66);
        check("ignore_remainder", remainder, 2);
        $display("div 200/3 with ignored start -> q=%0d r=%0d", quotient, remainder);
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        check("ignore_no_extra_op", pulses, 0);

        // Reset in the middle of a run aborts it.
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_dbz", div_by_zero, 0);
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        check("abort_no_done", pulses, 0);
        $display("div 100/7 aborted by reset");
        run_div(8'd50, 8'd6, 8'd8, 8'd2, 1'b0);

        // Start held high: one completion every 9 cycles.
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        pulses   = 0;
        last     = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy && done) check("stream_overlap", 1, 0);
            if (done) begin
                check("stream_quotient", quotient, 14);
                check("stream_remainder", remainder, 2);
                if (last >= 0) check("stream_period", i - last, 9);
                else check("stream_first", i, 8);
                last = i;
                pulses++;
                $display("stream done at cycle %0d q=%0d r=%0d", i, quotient, remainder);
            end
        end
        check("stream_pulses", pulses, 4);
        start = 1'b0;
        repeat (12) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/eight_bit_divider.md
# eight_bit_divider

Sequential 8-bit unsigned restoring divider: the inverse arithmetic direction of the datapath's ripple-carry add/subtract adder. It takes a dividend and divisor on a start strobe and performs one shift-and-trial-subtract step per clock for 8 clocks. It then presents the quotient and remainder with a one-cycle done pulse. It sits beside the adder in the arithmetic unit and serves operations that need division or modulo.

## Interface
- No parameters; width fixed at 8 bits.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request strobe; accepted only when idle (busy=0).
- dividend  input  8  unsigned dividend; sampled on the accepting edge only.
- divisor  input  8  unsigned divisor; sampled on the accepting edge only.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse when results become valid.
- quotient  output  8  unsigned quotient; holds its value until the next completion.
- remainder  output  8  unsigned remainder; holds its value until the next completion.
- div_by_zero  output  1  set with done when divisor was 0; holds its value until the next completion.

## Operation
- FSM states:
  - IDLE: the only state in which start is accepted.
  - RUN: 8 iterations, counted by a 3-bit counter 7→0.
  - A done pulse is generated on the exit edge; there is no separate DONE wait state.
- IDLE with start=1 and divisor≠0:
  - latch divisor D;
  - load quotient shift register Q=dividend;
  - set partial remainder R (9 bits) = 0;
  - set counter=7; go to RUN.
- IDLE with start=1 and divisor=0:
  - no iterations; at the same edge, register quotient=8'hFF, remainder=dividend, div_by_zero=1, done=1;
  - stay in IDLE.
- RUN iteration, per edge:
  - T = {R[7:0], Q[7]};
  - Q shifts left by 1;
  - if T ≥ {1'b0, D}: R = T − D and Q[0]=1; otherwise R = T and Q[0]=0.
- Comparison and subtraction are 9-bit unsigned; R never exceeds D−1 after an iteration.
- On the iteration with counter=0:
  - register quotient=final Q, remainder=R[7:0], div_by_zero=0, done=1;
  - return to IDLE.
- start while busy=1 is ignored. It is neither queued nor able to corrupt the latched operands.
- dividend and divisor changes after the accepting edge have no effect.

## Timing
- Reset values: FSM=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, internal R/Q/D/counter=0.
- rst has priority over everything. Reset mid-RUN aborts: no done pulse, and outputs are forced to their reset values.
- Normal latency, with start accepted at edge E0:
  - busy=1 from after E0;
  - iterations occur at E1..E8;
  - after E8: done=1, busy=0, results valid.
  - done therefore rises 8 cycles after busy rises.
- Divide-by-zero latency: done=1 and results valid right after E0; busy never asserts.
- done is high for exactly one cycle, then 0 unless a new completion occurs.
- Back-to-back operation: start held high during the done cycle is accepted, because the FSM is already IDLE. Throughput is one division per 9 cycles.
- busy and done are never high in the same cycle.
- quotient, remainder and div_by_zero change only on a completion edge or on reset.

## Test plan
- Reset, then dividend=100, divisor=7, start for 1 cycle → busy for 8 cycles, then done pulse with quotient=14, remainder=2, div_by_zero=0.
- Extreme values:
  - 255/1 → quotient=255, remainder=0.
  - 5/9 → quotient=0, remainder=5.
  - 255/255 → quotient=1, remainder=0.
  - 0/3 → quotient=0, remainder=0.
- 77/0 → done one cycle after the start edge with busy never high; quotient=8'hFF, remainder=77, div_by_zero=1. A following 77/5 → quotient=15, remainder=2, div_by_zero=0.
- Start 200/3, then pulse start with 9/2 and change the operands while busy → the request is ignored; result quotient=66, remainder=2 at the expected cycle.
- Start 100/7 and assert rst at iteration 4 → no done pulse, all outputs 0. A new 50/6 afterwards → quotient=8, remainder=2.
- Hold start high continuously with operands 100/7 → done pulse every 9 cycles, each with quotient=14, remainder=2.
